// File: rtl/scoreboard_pkg.sv
// Shared definitions for the scoreboard datapath: score width, default
// saturation bound, button FSM state encoding and the score-step rule.
// The auto-repeat states are only used when SCORE_AUTO_REPEAT_EN is defined.
package scoreboard_pkg;

  // Width of the binary score word handed to bin_to_decimal.
  localparam int SCORE_W           = 7;
  localparam int MAX_SCORE_DEFAULT = 99;

  // Per-button hold tracker (auto-repeat builds only).
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } btn_state_t;

  // One-cycle step requests arriving at the score register.
  typedef struct packed {
    logic clr;
    logic inc;
    logic dec;
  } score_evt_t;

  // Next score for one cycle of step requests. Clear wins outright; inc and
  // dec together cancel. Bounds are compared before the add/sub so the 7-bit
  // value never wraps at 0 or 127.
  function automatic logic [SCORE_W-1:0] score_next(
    input logic [SCORE_W-1:0] cur,
    input logic [SCORE_W-1:0] max_v,
    input score_evt_t         evt
  );
    logic [SCORE_W-1:0] nxt;
    nxt = cur;
    if (evt.clr) begin
      nxt = '0;
    end else if (evt.inc && !evt.dec) begin
      if (cur < max_v) nxt = cur + SCORE_W'(1);
    end else if (evt.dec && !evt.inc) begin
      if (cur != '0) nxt = cur - SCORE_W'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button front end: 2-FF synchroniser, stability-count debouncer,
// press detection and (with SCORE_AUTO_REPEAT_EN defined) an IDLE/HELD/REPEAT
// hold tracker that emits extra steps while the button stays down.
// step_o is a registered one-cycle pulse per score step requested.
module btn_debounce
  import scoreboard_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000
`ifdef SCORE_AUTO_REPEAT_EN
  , parameter int REPEAT_CYCLES = 50000
  , parameter bit REPEAT_EN     = 1'b1
`endif
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic btn_i,
  output logic step_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [1:0]       fill_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;
  logic             armed_q;

  logic sync_w;
  logic differ_w;
  logic flip_w;
  logic rise_w;

  assign sync_w   = sync_q[1];
  assign differ_w = (sync_w != level_q);
  // The debounced level changes on this edge.
  assign flip_w   = differ_w && (cnt_q == CNT_LAST);
  // Press edge; ignored until the button has been seen released after reset.
  assign rise_w   = flip_w && sync_w && armed_q;

  // Two-flop synchroniser; fill_q marks when sync_q reflects real samples.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= 2'b00;
      fill_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      fill_q <= {fill_q[0], 1'b1};
    end
  end

  // Debounce: count consecutive disagreeing samples, flip the level after a full run.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else if (!differ_w) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      level_q <= sync_w;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Arm once a genuinely released button is observed, so a button held
  // through reset release cannot produce a press.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      armed_q <= 1'b0;
    end else if (fill_q[1] && !sync_w && !level_q) begin
      armed_q <= 1'b1;
    end
  end

`ifdef SCORE_AUTO_REPEAT_EN
  localparam int HOLD_CYCLES = 4 * REPEAT_CYCLES;
  localparam int RPT_W       = $clog2(HOLD_CYCLES + 1);
  localparam logic [RPT_W-1:0] HOLD_LAST = RPT_W'(HOLD_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_LAST  = RPT_W'(REPEAT_CYCLES - 1);

  logic             fall_w;
  btn_state_t       state_q;
  logic [RPT_W-1:0] rpt_q;
  logic             step_q;

  assign fall_w = flip_w && !sync_w;

  // Hold tracker: step on press, again after the long hold, then periodically.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      rpt_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      step_q <= 1'b0;
      if (fall_w) begin
        state_q <= IDLE;
        rpt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (rise_w) begin
              state_q <= HELD;
              rpt_q   <= '0;
              step_q  <= 1'b1;
            end
          end
          HELD: begin
            if (REPEAT_EN) begin
              if (rpt_q == HOLD_LAST) begin
                state_q <= REPEAT;
                rpt_q   <= '0;
                step_q  <= 1'b1;
              end else begin
                rpt_q <= rpt_q + RPT_W'(1);
              end
            end
          end
          REPEAT: begin
            if (rpt_q == RPT_LAST) begin
              rpt_q  <= '0;
              step_q <= 1'b1;
            end else begin
              rpt_q <= rpt_q + RPT_W'(1);
            end
          end
          default: begin
            state_q <= IDLE;
            rpt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign step_o = step_q;
`else
  logic press_q;

  // One registered step per debounced press.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      press_q <= 1'b0;
    end else begin
      press_q <= rise_w;
    end
  end

  assign step_o = press_q;
`endif

endmodule

// File: rtl/score_counter.sv
// Score register ahead of the binary-to-decimal converter. Three raw buttons
// are cleaned up by btn_debounce; this module applies the clear/inc/dec
// priority with saturation at 0..MAX_SCORE and flags each actual change.
// Optional feature macro: SCORE_AUTO_REPEAT_EN (auto-repeat on held inc/dec).
module score_counter
  import scoreboard_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int MAX_SCORE       = MAX_SCORE_DEFAULT,
  parameter int REPEAT_CYCLES   = 50000
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         inc_btn_i,
  input  logic         dec_btn_i,
  input  logic         clr_btn_i,
  output logic [6:0]   score_o,
  output logic         changed_o
);

  // Parameter sanity, caught at elaboration.
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("score_counter: DEBOUNCE_CYCLES must be at least 2");
  end
  if ((MAX_SCORE < 1) || (MAX_SCORE > (2**SCORE_W) - 1)) begin : g_bad_max
    $error("score_counter: MAX_SCORE must fit the score width");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_repeat
    $error("score_counter: REPEAT_CYCLES must be positive");
  end

  localparam logic [SCORE_W-1:0] MAX_V = SCORE_W'(MAX_SCORE);

  logic inc_step;
  logic dec_step;
  logic clr_step;

`ifdef SCORE_AUTO_REPEAT_EN
  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES),
    .REPEAT_EN      (1'b1)
  ) u_inc (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .btn_i  (inc_btn_i),
    .step_o (inc_step)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES),
    .REPEAT_EN      (1'b1)
  ) u_dec (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .btn_i  (dec_btn_i),
    .step_o (dec_step)
  );

  // Clear never repeats while held.
  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES),
    .REPEAT_EN      (1'b0)
  ) u_clr (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .btn_i  (clr_btn_i),
    .step_o (clr_step)
  );
`else
  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_inc (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .btn_i  (inc_btn_i),
    .step_o (inc_step)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_dec (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .btn_i  (dec_btn_i),
    .step_o (dec_step)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_clr (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .btn_i  (clr_btn_i),
    .step_o (clr_step)
  );
`endif

  score_evt_t         evt;
  logic [SCORE_W-1:0] score_q;
  logic [SCORE_W-1:0] score_d;
  logic               changed_q;
  logic               changed_d;

  assign evt = '{clr: clr_step, inc: inc_step, dec: dec_step};

  // Priority and saturation; changed only when the value really moves.
  always_comb begin
    score_d   = score_next(score_q, MAX_V, evt);
    changed_d = (score_d != score_q);
  end

  // Output register: score and its change strobe.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      score_q   <= '0;
      changed_q <= 1'b0;
    end else begin
      score_q   <= score_d;
      changed_q <= changed_d;
    end
  end

  assign score_o   = score_q;
  assign changed_o = changed_q;

endmodule

// File: tb/tb_score_counter.sv
// Bench for score_counter with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8.
// Reference: integer score model plus a queue of expected (cycle, score)
// changes; a monitor checks every cycle that changed_o fires exactly then.
module tb_score_counter;

  localparam int DC   = 4;
  localparam int RC   = 8;
  localparam int MAXS = 99;
  // Drive happens just after edge k; capture is edge k+1; output updates at
  // capture+DC+2, i.e. sampled with cyc == k + DC + 3.
  localparam int LAT  = DC + 3;

  // ---------------- clock / reset ----------------
  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       inc   = 1'b0;
  logic       dec   = 1'b0;
  logic       clr   = 1'b0;
  logic [6:0] score;
  logic       changed;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  score_counter #(
    .DEBOUNCE_CYCLES(DC),
    .MAX_SCORE      (MAXS),
    .REPEAT_CYCLES  (RC)
  ) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .inc_btn_i(inc),
    .dec_btn_i(dec),
    .clr_btn_i(clr),
    .score_o  (score),
    .changed_o(changed)
  );

  // ---------------- scoreboard ----------------
  int         total = 0;
  int         bad   = 0;
  int         model_score = 0;
  int         pulse_cnt = 0;
  logic [6:0] exp_q[$];
  int         exp_cyc_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Score rules at integer level; schedules the expected change cycle.
  task automatic model_apply(input bit c, input bit i, input bit d, input int at);
    int old;
    old = model_score;
    if (c) model_score = 0;
    else if (i && !d) model_score = (model_score < MAXS) ? model_score + 1 : model_score;
    else if (d && !i) model_score = (model_score > 0) ? model_score - 1 : 0;
    if (model_score != old) begin
      exp_cyc_q.push_back(at);
      exp_q.push_back(7'(model_score));
    end
  endtask

  // Monitor: changed_o must pulse exactly on scheduled cycles with the right score.
  always begin
    @(posedge clk);
    #3;
    if (rst_n) begin
      if (changed) pulse_cnt++;
      if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
        check_eq("changed_pulse", changed, 1);
        check_eq("score_at_change", score, exp_q[0]);
        void'(exp_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end else begin
        check_eq("changed_idle", changed, 0);
      end
    end
  end

  // ---------------- drivers ----------------
  // Press a button combination for 'hold' cycles, then release for 'gap'.
  // Optional leading bounce: one cycle high, one cycle low.
  task automatic press(input bit c, input bit i, input bit d,
                       input int hold, input int gap, input bit bounce);
    int base;
    @(posedge clk); #1;
    if (bounce) begin
      clr = c; inc = i; dec = d;
      @(posedge clk); #1;
      clr = 0; inc = 0; dec = 0;
      @(posedge clk); #1;
    end
    clr = c; inc = i; dec = d;
    base = cyc + LAT;
    model_apply(c, i, d, base);
`ifdef SCORE_AUTO_REPEAT_EN
    // Held inc/dec: extra steps at 4*RC after the first, then every RC,
    // as long as the debounced level is still high.
    if (!c) begin
      for (int off = 4 * RC; off < hold; off += RC) model_apply(c, i, d, base + off);
    end
`endif
    repeat (hold) @(posedge clk);
    #1;
    clr = 0; inc = 0; dec = 0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic check_score(input string tag, input int want);
    @(posedge clk); #4;
    check_eq(tag, score, want);
  endtask

  // ---------------- stimulus ----------------
  int p0;
  int r;

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #4;
    check_eq("reset_score", score, 0);
    check_eq("reset_changed", changed, 0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // 1: three clean presses -> 1, 2, 3 with exactly three pulses
    p0 = pulse_cnt;
    for (int k = 0; k < 3; k++) begin
      press(0, 1, 0, 20, 8, 0);
      check_score("t1_score", k + 1);
    end
    check_eq("t1_pulses", pulse_cnt - p0, 3);

    // 2: short pulse then glitch train -> nothing
    p0 = pulse_cnt;
    @(posedge clk); #1;
    inc = 1;
    repeat (3) @(posedge clk);
    #1; inc = 0;
    @(posedge clk); #1;
    for (int t = 0; t < 5; t++) begin
      inc = ((t / 2) % 2 == 0);
      @(posedge clk); #1;
    end
    inc = 0;
    repeat (15) @(posedge clk);
    check_score("t2_score", 3);
    check_eq("t2_pulses", pulse_cnt - p0, 0);

    // 3: saturation at MAX and at 0
    while (model_score < MAXS) press(0, 1, 0, 6, 8, 0);
    check_score("t3_at_max", MAXS);
    p0 = pulse_cnt;
    press(0, 1, 0, 6, 8, 0);
    check_score("t3_inc_sat", MAXS);
    check_eq("t3_inc_sat_pulse", pulse_cnt - p0, 0);
    press(1, 0, 0, 6, 8, 0);
    check_score("t3_clr", 0);
    p0 = pulse_cnt;
    press(0, 0, 1, 6, 8, 0);
    check_score("t3_dec_sat", 0);
    check_eq("t3_dec_sat_pulse", pulse_cnt - p0, 0);

    // 4: inc+dec cancel, clr beats inc
    while (model_score < 42) press(0, 1, 0, 6, 8, 0);
    p0 = pulse_cnt;
    press(0, 1, 1, 6, 8, 0);
    check_score("t4_inc_dec", 42);
    check_eq("t4_inc_dec_pulse", pulse_cnt - p0, 0);
    press(1, 1, 0, 6, 8, 0);
    check_score("t4_clr_inc", 0);
    check_eq("t4_clr_inc_pulse", pulse_cnt - p0, 1);

    // 5: reset while inc held; the held press must not count afterwards
    while (model_score < 17) press(0, 1, 0, 6, 8, 0);
    @(posedge clk); #1;
    inc = 1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    exp_cyc_q.delete();
    model_score = 0;
    #1;
    check_eq("t5_async_score", score, 0);
    check_eq("t5_async_changed", changed, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    p0 = pulse_cnt;
    repeat (20) @(posedge clk);
    check_score("t5_held_no_count", 0);
    check_eq("t5_held_pulses", pulse_cnt - p0, 0);
    #1; inc = 0;
    repeat (10) @(posedge clk);
    press(0, 1, 0, 8, 8, 0);
    check_score("t5_repress", 1);

    // 6: long hold from 0 (one step without auto-repeat)
    press(1, 0, 0, 6, 8, 0);
    check_score("t6_start", 0);
    press(0, 1, 0, 70, 12, 0);
    check_score("t6_long_hold", model_score);
`ifndef SCORE_AUTO_REPEAT_EN
    check_eq("t6_single_step", score, 1);
`endif

    // Randomised button mix against the model
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: press(0, 1, 0, $urandom_range(6, 15), $urandom_range(8, 14), 1'($urandom_range(0, 1)));
        4, 5, 6:    press(0, 0, 1, $urandom_range(6, 15), $urandom_range(8, 14), 1'($urandom_range(0, 1)));
        7:          press(1, 0, 0, $urandom_range(6, 15), $urandom_range(8, 14), 1'($urandom_range(0, 1)));
        8:          press(0, 1, 1, $urandom_range(6, 15), $urandom_range(8, 14), 1'($urandom_range(0, 1)));
        default:    press(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          $urandom_range(6, 15), $urandom_range(8, 14), 1'($urandom_range(0, 1)));
      endcase
      check_score("rand_score", model_score);
    end

    repeat (10) @(posedge clk);
    #4;
    check_eq("pending_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
